// File: rtl/gearbox_fifo.sv
// -----------------------------------------------------------------------------
// gearbox_fifo
//
// Width-down-converting first-word-fall-through FIFO. Each write pushes one
// entry of RATIO read-words (lane 0 in the low bits); reads pop one read-word
// at a time, lowest lane first. Sits between a wide burst ingress and a
// narrower datapath consumer.
//
// Ports:
//   clk              : clock, all state on the rising edge
//   rst              : asynchronous reset, active low
//   write_en         : push write_data this edge unless full
//   write_data       : RATIO lanes of RD_WIDTH bits, lane 0 = low bits
//   read             : pop read_data this edge unless empty
//   read_data        : current head word, 0 when empty
//   level            : unread read-words stored
//   fifo_empty       : level == 0
//   fifo_full        : all DEPTH entries occupied (partially read counts)
//   fifo_half_full   : level >= DEPTH*RATIO/2
//   fifo_almost_full : level >= AF_LEVEL
//   overflow         : sticky, write attempted while full
//   underflow        : sticky, read attempted while empty
//
// Configuration macro:
//   GEARBOX_FIFO_ERR_EN : when defined, overflow/underflow are sticky
//                         registers cleared only by reset; otherwise both
//                         outputs are tied to 0 and no error state exists.
// -----------------------------------------------------------------------------

// One lane of storage: DEPTH words of W bits, written as part of a whole
// entry, read asynchronously at the read-entry pointer.
module gearbox_fifo_lane #(
    parameter int W     = 64,
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [PW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    // Storage is deliberately not reset.
    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

module gearbox_fifo #(
    parameter int RD_WIDTH = 64,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH*RATIO-2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write_en,
    input  logic [RD_WIDTH*RATIO-1:0]     write_data,
    input  logic                          read,
    output logic [RD_WIDTH-1:0]           read_data,
    output logic [$clog2(DEPTH*RATIO):0]  level,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic                          fifo_half_full,
    output logic                          fifo_almost_full,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW  = $clog2(DEPTH+1);
    localparam int LVW = $clog2(DEPTH*RATIO)+1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] lane_q,   lane_d;
    logic [CW-1:0] cnt_q,    cnt_d;

    logic empty, full;
    logic wr_acc, rd_acc, retire;

    logic [RATIO-1:0][RD_WIDTH-1:0] lane_rd;
    logic [RD_WIDTH-1:0]            rd_mux;
    logic [LVW-1:0]                 level_w;

    // Gating uses pre-edge flags only: a write while full is dropped even if
    // this edge retires an entry, and a read while empty is ignored even if
    // a write lands on the same edge.
    always_comb begin
        empty  = (cnt_q == '0);
        full   = (cnt_q == CW'(DEPTH));
        wr_acc = write_en && !full;
        rd_acc = read && !empty;
        // With RATIO=1 the last-lane compare is always true, so every read
        // retires an entry and lane_q stays at 0.
        retire = rd_acc && (lane_q == LW'(RATIO-1));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) begin
            if (retire) begin
                lane_d   = '0;
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                lane_d   = lane_q + LW'(1);
            end
        end
        case ({wr_acc, retire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lane_q   <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar g = 0; g < RATIO; g++) begin : g_lane
        gearbox_fifo_lane #(
            .W     (RD_WIDTH),
            .DEPTH (DEPTH),
            .PW    (PW)
        ) u_lane (
            .clk   (clk),
            .we    (wr_acc),
            .waddr (wr_ptr_q),
            .wdata (write_data[g*RD_WIDTH +: RD_WIDTH]),
            .raddr (rd_ptr_q),
            .rdata (lane_rd[g])
        );
    end

    // Head-word select; forced to zero when empty so stale storage never
    // leaks onto the output.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (!empty && lane_q == LW'(i)) rd_mux = lane_rd[i];
        end
    end

    // Lanes already consumed from the head entry are subtracted out.
    assign level_w = LVW'(cnt_q) * LVW'(RATIO) - LVW'(lane_q);

    assign read_data        = rd_mux;
    assign level            = level_w;
    assign fifo_empty       = empty;
    assign fifo_full        = full;
    assign fifo_half_full   = (level_w >= LVW'(DEPTH*RATIO/2));
    assign fifo_almost_full = (32'(level_w) >= 32'(AF_LEVEL));

`ifdef GEARBOX_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q | (write_en && full);
        udf_d = udf_q | (read && empty);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule
